// File: rtl/load_store_queue_if.sv
// Enqueue and memory-issue handshake bundle for the load/store queue.
// The master side feeds entries in and accepts issues; the slave side is the queue.
interface load_store_queue_if #(
    parameter int ROB_W = 4
) ();
    logic             enq_valid;
    logic             enq_ready;
    logic             enq_typ;
    logic [2:0]       enq_op;
    logic [31:0]      enq_Vj;
    logic [31:0]      enq_Vk;
    logic [ROB_W-1:0] enq_Qj;
    logic [ROB_W-1:0] enq_Qk;
    logic [ROB_W-1:0] enq_dest;
    logic [11:0]      enq_offset;

    logic             mem_valid;
    logic             mem_ready;
    logic             mem_typ;
    logic [2:0]       mem_op;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_data;
    logic [ROB_W-1:0] mem_dest;

    modport master (
        output enq_valid, enq_typ, enq_op, enq_Vj, enq_Vk, enq_Qj, enq_Qk, enq_dest, enq_offset,
        input  enq_ready,
        input  mem_valid, mem_typ, mem_op, mem_addr, mem_data, mem_dest,
        output mem_ready
    );

    modport slave (
        input  enq_valid, enq_typ, enq_op, enq_Vj, enq_Vk, enq_Qj, enq_Qk, enq_dest, enq_offset,
        output enq_ready,
        output mem_valid, mem_typ, mem_op, mem_addr, mem_data, mem_dest,
        input  mem_ready
    );
endinterface

// File: rtl/load_store_queue.sv
// In-order load/store queue: entries snoop the CDB for operands and wait for ROB commit
// (stores only) before issuing to memory strictly in program order.
module load_store_queue #(
    parameter int DEPTH   = 8,
    parameter int ROB_W   = 4,
    parameter int NUM_CDB = 2
) (
    input  logic                        clk_in,
    input  logic                        flush_input,
    load_store_queue_if.slave           bus,
    input  logic [NUM_CDB*ROB_W-1:0]    cdb_rob_id,
    input  logic [NUM_CDB*32-1:0]       cdb_value,
    input  logic [ROB_W-1:0]            rob_commit_id,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        full,
    output logic                        empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] is_store;
    logic [DEPTH-1:0] committed;
    logic [2:0]       op     [DEPTH];
    logic [31:0]      vj     [DEPTH];
    logic [31:0]      vk     [DEPTH];
    logic [ROB_W-1:0] qj     [DEPTH];
    logic [ROB_W-1:0] qk     [DEPTH];
    logic [ROB_W-1:0] dest   [DEPTH];
    logic [11:0]      offset [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] used;

    logic             head_ready;
    logic             enq_fire;
    logic             deq_fire;
    logic [32:0]      snoop_j [DEPTH];
    logic [32:0]      snoop_k [DEPTH];
    logic [32:0]      enq_snoop_j;
    logic [32:0]      enq_snoop_k;

    // Returns {hit, value}; scanning high to low lets the lowest channel win.
    function automatic logic [32:0] cdb_lookup(
        input logic [ROB_W-1:0]         q,
        input logic [NUM_CDB*ROB_W-1:0] ids,
        input logic [NUM_CDB*32-1:0]    vals
    );
        logic [32:0] r;
        r = '0;
        for (int c = NUM_CDB - 1; c >= 0; c--) begin
            if (q != '0 && ids[c*ROB_W +: ROB_W] == q)
                r = {1'b1, vals[c*32 +: 32]};
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            snoop_j[i] = cdb_lookup(qj[i], cdb_rob_id, cdb_value);
            snoop_k[i] = cdb_lookup(qk[i], cdb_rob_id, cdb_value);
        end
        enq_snoop_j = cdb_lookup(bus.enq_Qj, cdb_rob_id, cdb_value);
        enq_snoop_k = cdb_lookup(bus.enq_Qk, cdb_rob_id, cdb_value);
    end

    assign count         = used;
    assign full          = (used == CNT_W'(DEPTH));
    assign empty         = (used == '0);
    assign bus.enq_ready = !full;
    assign enq_fire      = bus.enq_valid && !full;

    // Loads only need their base operand; stores also need data and a retired ROB slot.
    always_comb begin
        head_ready = busy[head] && (qj[head] == '0);
        if (is_store[head])
            head_ready = head_ready && (qk[head] == '0) && committed[head];
    end

    assign bus.mem_valid = !empty && head_ready;
    assign deq_fire      = bus.mem_valid && bus.mem_ready;

    always_comb begin
        bus.mem_typ  = 1'b0;
        bus.mem_op   = '0;
        bus.mem_addr = '0;
        bus.mem_data = '0;
        bus.mem_dest = '0;
        if (bus.mem_valid) begin
            bus.mem_typ  = is_store[head];
            bus.mem_op   = op[head];
            bus.mem_addr = vj[head] + {{20{offset[head][11]}}, offset[head]};
            bus.mem_data = is_store[head] ? vk[head] : 32'd0;
            bus.mem_dest = dest[head];
        end
    end

    always_ff @(posedge clk_in) begin
        if (flush_input) begin
            head <= '0;
            tail <= '0;
            used <= '0;
            busy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy[i] && snoop_j[i][32]) begin
                    vj[i] <= snoop_j[i][31:0];
                    qj[i] <= '0;
                end
                if (busy[i] && snoop_k[i][32]) begin
                    vk[i] <= snoop_k[i][31:0];
                    qk[i] <= '0;
                end
                if (busy[i] && rob_commit_id != '0 && dest[i] == rob_commit_id)
                    committed[i] <= 1'b1;
            end

            if (deq_fire) begin
                busy[head] <= 1'b0;
                head       <= head + PTR_W'(1);
            end

            // The tail slot is never busy when enqueue is allowed, so these writes cannot collide.
            if (enq_fire) begin
                busy[tail]      <= 1'b1;
                is_store[tail]  <= bus.enq_typ;
                op[tail]        <= bus.enq_op;
                vj[tail]        <= enq_snoop_j[32] ? enq_snoop_j[31:0] : bus.enq_Vj;
                vk[tail]        <= enq_snoop_k[32] ? enq_snoop_k[31:0] : bus.enq_Vk;
                qj[tail]        <= enq_snoop_j[32] ? '0 : bus.enq_Qj;
                qk[tail]        <= enq_snoop_k[32] ? '0 : bus.enq_Qk;
                dest[tail]      <= bus.enq_dest;
                offset[tail]    <= bus.enq_offset;
                committed[tail] <= (rob_commit_id != '0) && (rob_commit_id == bus.enq_dest);
                tail            <= tail + PTR_W'(1);
            end

            used <= used + CNT_W'(enq_fire) - CNT_W'(deq_fire);
        end
    end
endmodule

// File: tb/tb_load_store_queue.sv
// Scoreboard bench for load_store_queue: directed entries push expected issues,
// a negedge monitor pops and compares every memory issue.
module tb_load_store_queue;
    localparam int DEPTH   = 8;
    localparam int ROB_W   = 4;
    localparam int NUM_CDB = 2;

    typedef struct packed {
        logic        typ;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  dest;
    } exp_t;

    logic                     clk;
    logic                     flush_input;
    logic [NUM_CDB*ROB_W-1:0] cdb_rob_id;
    logic [NUM_CDB*32-1:0]    cdb_value;
    logic [ROB_W-1:0]         rob_commit_id;
    logic [$clog2(DEPTH):0]   count;
    logic                     full;
    logic                     empty;

    int   checks;
    int   passes;
    bit   started;
    exp_t exp_q[$];
    exp_t e;

    load_store_queue_if #(.ROB_W(ROB_W)) bus ();

    load_store_queue #(
        .DEPTH(DEPTH), .ROB_W(ROB_W), .NUM_CDB(NUM_CDB)
    ) dut (
        .clk_in(clk),
        .flush_input(flush_input),
        .bus(bus),
        .cdb_rob_id(cdb_rob_id),
        .cdb_value(cdb_value),
        .rob_commit_id(rob_commit_id),
        .count(count),
        .full(full),
        .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    endtask

    // One-cycle enqueue; when the entry should eventually issue, its hand-computed result is queued.
    task automatic applyStimulus(
        input logic typ, input logic [2:0] op, input logic [31:0] vj, input logic [31:0] vk,
        input logic [3:0] qj, input logic [3:0] qk, input logic [3:0] dest, input logic [11:0] off,
        input bit expect_issue, input logic [31:0] exp_addr, input logic [31:0] exp_data
    );
        exp_t x;
        bus.enq_valid  = 1'b1;
        bus.enq_typ    = typ;
        bus.enq_op     = op;
        bus.enq_Vj     = vj;
        bus.enq_Vk     = vk;
        bus.enq_Qj     = qj;
        bus.enq_Qk     = qk;
        bus.enq_dest   = dest;
        bus.enq_offset = off;
        if (expect_issue) begin
            x.typ  = typ;
            x.op   = op;
            x.addr = exp_addr;
            x.data = exp_data;
            x.dest = dest;
            exp_q.push_back(x);
        end
        tick();
        bus.enq_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (started && !flush_input) begin
            if (bus.mem_valid && bus.mem_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL unexpected_issue: actual addr 0x%0h dest %0d, required no issue",
                             bus.mem_addr, bus.mem_dest);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("issue_typ",  32'(bus.mem_typ),  32'(e.typ));
                    checkOutput("issue_op",   32'(bus.mem_op),   32'(e.op));
                    checkOutput("issue_addr", bus.mem_addr,      e.addr);
                    checkOutput("issue_data", bus.mem_data,      e.data);
                    checkOutput("issue_dest", 32'(bus.mem_dest), 32'(e.dest));
                end
            end else if (!bus.mem_valid) begin
                checkOutput("idle_outputs_zero",
                            32'(bus.mem_typ) | 32'(bus.mem_op) | bus.mem_addr | bus.mem_data | 32'(bus.mem_dest),
                            32'd0);
            end
        end
    end

    initial begin
        #100000;
        checks++;
        $display("[TB] FAIL timeout: actual simulation still running, required completion");
        $display("%0d/%0d checks passed", passes, checks);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        checks = 0;
        passes = 0;
        started = 1'b0;
        bus.enq_valid = 1'b0;
        bus.enq_typ = 1'b0;
        bus.enq_op = '0;
        bus.enq_Vj = '0;
        bus.enq_Vk = '0;
        bus.enq_Qj = '0;
        bus.enq_Qk = '0;
        bus.enq_dest = '0;
        bus.enq_offset = '0;
        bus.mem_ready = 1'b0;
        cdb_rob_id = '0;
        cdb_value = '0;
        rob_commit_id = '0;
        flush_input = 1'b1;
        tick();
        tick();
        flush_input = 1'b0;
        started = 1'b1;

        checkOutput("rst_empty",     32'(empty),         32'd1);
        checkOutput("rst_full",      32'(full),          32'd0);
        checkOutput("rst_count",     32'(count),         32'd0);
        checkOutput("rst_enq_ready", 32'(bus.enq_ready), 32'd1);
        checkOutput("rst_mem_valid", 32'(bus.mem_valid), 32'd0);

        // Ready load: 0x1000 + sext(0xFFC) = 0x0FFC.
        bus.mem_ready = 1'b1;
        applyStimulus(1'b0, 3'd2, 32'h1000, 32'h0, 4'd0, 4'd0, 4'd3, 12'hFFC, 1'b1, 32'h0000_0FFC, 32'h0);
        checkOutput("t1_mem_valid", 32'(bus.mem_valid), 32'd1);
        checkOutput("t1_mem_addr",  bus.mem_addr,       32'h0000_0FFC);
        checkOutput("t1_mem_dest",  32'(bus.mem_dest),  32'd3);
        tick();
        checkOutput("t1_empty", 32'(empty), 32'd1);

        // Store waiting on ROB 2 for data, then on its own commit.
        applyStimulus(1'b1, 3'd2, 32'h2000, 32'hDEAD, 4'd0, 4'd2, 4'd5, 12'h010, 1'b1, 32'h2010, 32'hAB);
        checkOutput("t2_wait_data", 32'(bus.mem_valid), 32'd0);
        cdb_rob_id = {4'd2, 4'd0};
        cdb_value  = {32'hAB, 32'h0};
        tick();
        cdb_rob_id = '0;
        cdb_value  = '0;
        checkOutput("t2_wait_commit_a", 32'(bus.mem_valid), 32'd0);
        tick();
        checkOutput("t2_wait_commit_b", 32'(bus.mem_valid), 32'd0);
        rob_commit_id = 4'd5;
        tick();
        rob_commit_id = '0;
        checkOutput("t2_mem_valid", 32'(bus.mem_valid), 32'd1);
        checkOutput("t2_mem_data",  bus.mem_data,       32'hAB);
        checkOutput("t2_mem_typ",   32'(bus.mem_typ),   32'd1);
        tick();
        checkOutput("t2_empty", 32'(empty), 32'd1);

        // Both channels broadcast id 4 during enqueue; channel 0 (0x11) must win.
        cdb_rob_id = {4'd4, 4'd4};
        cdb_value  = {32'h22, 32'h11};
        applyStimulus(1'b0, 3'd2, 32'hFFFF_0000, 32'h0, 4'd4, 4'd0, 4'd9, 12'h000, 1'b1, 32'h11, 32'h0);
        cdb_rob_id = '0;
        cdb_value  = '0;
        checkOutput("t3_mem_valid", 32'(bus.mem_valid), 32'd1);
        checkOutput("t3_mem_addr",  bus.mem_addr,       32'h11);
        tick();
        checkOutput("t3_empty", 32'(empty), 32'd1);

        // Backpressure: outputs hold while mem_ready is low.
        bus.mem_ready = 1'b0;
        applyStimulus(1'b0, 3'd4, 32'h300, 32'h0, 4'd0, 4'd0, 4'd6, 12'h008, 1'b1, 32'h308, 32'h0);
        for (int k = 0; k < 3; k++) begin
            checkOutput("t4_hold_valid", 32'(bus.mem_valid), 32'd1);
            checkOutput("t4_hold_addr",  bus.mem_addr,       32'h308);
            checkOutput("t4_hold_dest",  32'(bus.mem_dest),  32'd6);
            checkOutput("t4_hold_count", 32'(count),         32'd1);
            tick();
        end
        bus.mem_ready = 1'b1;
        tick();
        checkOutput("t4_empty", 32'(empty), 32'd1);

        // Simultaneous enqueue and dequeue keeps count steady.
        bus.mem_ready = 1'b0;
        applyStimulus(1'b0, 3'd0, 32'h500, 32'h0, 4'd0, 4'd0, 4'd10, 12'h000, 1'b1, 32'h500, 32'h0);
        bus.mem_ready = 1'b1;
        applyStimulus(1'b0, 3'd1, 32'h600, 32'h0, 4'd0, 4'd0, 4'd11, 12'h004, 1'b1, 32'h604, 32'h0);
        checkOutput("t4b_count_same", 32'(count), 32'd1);
        tick();
        checkOutput("t4b_empty", 32'(empty), 32'd1);

        // Fill behind an uncommitted store (pointers start at 6, so this wraps).
        applyStimulus(1'b1, 3'd2, 32'h4000, 32'h77, 4'd0, 4'd0, 4'd7, 12'h000, 1'b1, 32'h4000, 32'h77);
        for (int k = 0; k < 7; k++)
            applyStimulus(1'b0, 3'd2, 32'h100 * (k + 1), 32'h0, 4'd0, 4'd0, 4'(8 + k), 12'(k * 4),
                          1'b1, 32'h100 * (k + 1) + 32'(k * 4), 32'h0);
        checkOutput("t5_full",      32'(full),          32'd1);
        checkOutput("t5_enq_ready", 32'(bus.enq_ready), 32'd0);
        checkOutput("t5_count",     32'(count),         32'd8);
        checkOutput("t5_blocked",   32'(bus.mem_valid), 32'd0);
        applyStimulus(1'b0, 3'd2, 32'h999, 32'h0, 4'd0, 4'd0, 4'd15, 12'h000, 1'b0, 32'h0, 32'h0);
        checkOutput("t5_drop_count", 32'(count), 32'd8);
        rob_commit_id = 4'd7;
        tick();
        rob_commit_id = '0;
        for (int i = 0; i < 8; i++) begin
            checkOutput("t5_drain_count", 32'(count), 32'(8 - i));
            tick();
        end
        checkOutput("t5_empty", 32'(empty), 32'd1);

        // Flush with five ready entries and an issue on offer.
        bus.mem_ready = 1'b0;
        for (int k = 0; k < 5; k++)
            applyStimulus(1'b0, 3'd2, 32'h8000, 32'h0, 4'd0, 4'd0, 4'(1 + k), 12'h000, 1'b0, 32'h0, 32'h0);
        checkOutput("t6_count_pre", 32'(count),         32'd5);
        checkOutput("t6_valid_pre", 32'(bus.mem_valid), 32'd1);
        bus.mem_ready = 1'b1;
        flush_input = 1'b1;
        tick();
        flush_input = 1'b0;
        checkOutput("t6_count",     32'(count),         32'd0);
        checkOutput("t6_mem_valid", 32'(bus.mem_valid), 32'd0);
        checkOutput("t6_enq_ready", 32'(bus.enq_ready), 32'd1);
        checkOutput("t6_empty",     32'(empty),         32'd1);
        tick();
        tick();

        checkOutput("sb_pending", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
